// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: ID-side fields, forwarding sources and EX-side ALU/control outputs of the ID/EX stage
interface id_ex_operand_stage_if #(
    parameter int XLEN   = 32,
    parameter int CARD_W = 5
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [4:0]        id_rd_addr;
    logic [CARD_W-1:0] id_alu_card;
    logic              id_alu_cin;
    logic              id_use_pc;
    logic              id_use_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              stall;
    logic              flush;
    logic [4:0]        mem_rd_addr;
    logic              mem_reg_write;
    logic [XLEN-1:0]   mem_result;
    logic [4:0]        wb_rd_addr;
    logic              wb_reg_write;
    logic [XLEN-1:0]   wb_result;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic              alu_cin;
    logic [CARD_W-1:0] alu_card;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [4:0]        ex_rd_addr;
    logic [XLEN-1:0]   ex_store_data;
    logic              hazard_stall;

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
               id_rd_addr, id_alu_card, id_alu_cin, id_use_pc, id_use_imm, id_reg_write,
               id_mem_read, id_mem_write, stall, flush, mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result,
        output alu_a, alu_b, alu_cin, alu_card, ex_valid, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_rd_addr, ex_store_data, hazard_stall
    );

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
               id_rd_addr, id_alu_card, id_alu_cin, id_use_pc, id_use_imm, id_reg_write,
               id_mem_read, id_mem_write, stall, flush, mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result,
        input  alu_a, alu_b, alu_cin, alu_card, ex_valid, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_rd_addr, ex_store_data, hazard_stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register, operand select with MEM/WB forwarding (FORWARD_EN) and hazard detection
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CARD_W = 5
) (
    input logic clk,
    input logic rst,
    id_ex_operand_stage_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [XLEN-1:0]   pc;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rd;
        logic [CARD_W-1:0] card;
        logic              cin;
        logic              use_pc;
        logic              use_imm;
    } ex_t;

    ex_t r;
    ex_t cap;
    logic hz;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // ID fields as captured on an ordinary advance; an empty ID slot becomes an all-zero bubble
    always_comb begin
        cap = '{
            valid:     1'b1,
            reg_write: bus.id_reg_write,
            mem_read:  bus.id_mem_read,
            mem_write: bus.id_mem_write,
            pc:        bus.id_pc,
            rs1_addr:  bus.id_rs1_addr,
            rs2_addr:  bus.id_rs2_addr,
            rs1_data:  bus.id_rs1_data,
            rs2_data:  bus.id_rs2_data,
            imm:       bus.id_imm,
            rd:        bus.id_rd_addr,
            card:      bus.id_alu_card,
            cin:       bus.id_alu_cin,
            use_pc:    bus.id_use_pc,
            use_imm:   bus.id_use_imm
        };
        cap = bus.id_valid ? cap : '0;
    end

    // flush beats stall; stall holds; a hazard turns the advance into a bubble
    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            r <= '0;
        else if (!bus.stall)
            r <= hz ? '0 : cap;
    end

`ifdef FORWARD_EN
    // MEM result is newer than WB, so it wins; x0 is excluded by the rd != 0 test
    always_comb begin
        fwd_rs1 = (bus.mem_reg_write && bus.mem_rd_addr != 5'd0 && bus.mem_rd_addr == r.rs1_addr) ? bus.mem_result :
                  (bus.wb_reg_write  && bus.wb_rd_addr  != 5'd0 && bus.wb_rd_addr  == r.rs1_addr) ? bus.wb_result  :
                  r.rs1_data;
        fwd_rs2 = (bus.mem_reg_write && bus.mem_rd_addr != 5'd0 && bus.mem_rd_addr == r.rs2_addr) ? bus.mem_result :
                  (bus.wb_reg_write  && bus.wb_rd_addr  != 5'd0 && bus.wb_rd_addr  == r.rs2_addr) ? bus.wb_result  :
                  r.rs2_data;
    end

    // only a load in EX cannot be forwarded in time, so only load-use stalls
    always_comb begin
        hz = bus.id_valid && !bus.flush && r.valid && r.mem_read && r.rd != 5'd0 &&
             (r.rd == bus.id_rs1_addr || r.rd == bus.id_rs2_addr);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.mem_result, bus.wb_rd_addr, bus.wb_reg_write, bus.wb_result};

    // without forwarding the register file value is used directly
    always_comb begin
        fwd_rs1 = r.rs1_data;
        fwd_rs2 = r.rs2_data;
    end

    // any pending write in EX or MEM to a source register stalls; WB is covered by the write-first register file
    always_comb begin
        hz = bus.id_valid && !bus.flush && (
             (bus.id_rs1_addr != 5'd0 && ((r.valid && r.reg_write && r.rd == bus.id_rs1_addr) ||
                                          (bus.mem_reg_write && bus.mem_rd_addr == bus.id_rs1_addr))) ||
             (bus.id_rs2_addr != 5'd0 && ((r.valid && r.reg_write && r.rd == bus.id_rs2_addr) ||
                                          (bus.mem_reg_write && bus.mem_rd_addr == bus.id_rs2_addr))));
    end
`endif

    assign bus.alu_a         = r.use_pc ? r.pc : fwd_rs1;
    assign bus.alu_b         = r.use_imm ? r.imm : fwd_rs2;
    assign bus.alu_cin       = r.cin;
    assign bus.alu_card      = r.card;
    assign bus.ex_valid      = r.valid;
    assign bus.ex_reg_write  = r.reg_write;
    assign bus.ex_mem_read   = r.mem_read;
    assign bus.ex_mem_write  = r.mem_write;
    assign bus.ex_rd_addr    = r.rd;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.hazard_stall  = hz;
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-select stage of the 5-stage RV32 core. It sits directly upstream of the ALU and drives its A, B, Cin and 5-bit Card inputs. It registers decoded fields, forwards results from MEM and WB, and detects load-use hazards. It inserts bubbles on hazard and flush, and holds state on an external stall.

## Interface
Parameters:
- XLEN, 32, datapath width
- CARD_W, 5, ALU opcode width (Card 5'b00000 = no-op, ALU output 0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rd_addr  in  5  destination index
- id_alu_card  in  CARD_W  ALU operation
- id_alu_cin  in  1  ALU carry-in
- id_use_pc  in  1  A operand = PC instead of rs1
- id_use_imm  in  1  B operand = imm instead of rs2
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- stall  in  1  external hold (memory wait)
- flush  in  1  branch/jump redirect, kill ID instruction
- mem_rd_addr  in  5, mem_reg_write  in  1, mem_result  in  XLEN  EX/MEM producer
- wb_rd_addr  in  5, wb_reg_write  in  1, wb_result  in  XLEN  MEM/WB producer
- alu_a, alu_b  out  XLEN  ALU operands
- alu_cin  out  1  ALU carry-in
- alu_card  out  CARD_W  ALU opcode
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_rd_addr  out  5  registered destination
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- hazard_stall  out  1  to ID/IF: hold PC and IF/ID this cycle

## Operation
- The registered fields are pc, rs1/rs2 addr+data, imm, rd, card, cin, use_pc, use_imm and the control bits.
- Register update priority at each rising edge:
  - rst: all fields 0.
  - flush: load bubble.
  - stall: hold.
  - hazard_stall: load bubble.
  - otherwise: capture ID fields. If id_valid=0, capture a bubble.
- A bubble sets valid=0, reg_write=mem_read=mem_write=0, card=5'b00000 and cin=0. Data fields are don't-care but are driven 0.
- Forwarding is combinational on the registered rs addresses, once per source.
  - Match mem_rd_addr first: requires mem_reg_write=1 and addr≠0.
  - Then match wb_rd_addr: requires wb_reg_write=1 and addr≠0.
  - Else use the registered rf data.
  - x0 is never forwarded.
- alu_a = registered pc when use_pc=1, else fwd_rs1.
- alu_b = registered imm when use_imm=1, else fwd_rs2.
- ex_store_data = fwd_rs2, always.
- Load-use hazard: hazard_stall=1 when all of the following hold:
  - ex_valid and ex_mem_read are both 1;
  - ex_rd_addr≠0;
  - ex_rd_addr equals id_rs1_addr or id_rs2_addr;
  - id_valid=1.
- hazard_stall is forced 0 while flush=1; the flushed instruction cannot hazard.
- While stall=1, hazard_stall is still computed. The register holds and no bubble is inserted.

## Timing
- Register path latency is 1 cycle, ID to EX.
- The operand mux is combinational, registered state to alu_a/alu_b, and adds zero cycles.
- After reset, all outputs are 0, including hazard_stall (ex_valid=0 forces it low).
- Load-use costs exactly 1 bubble cycle. The next cycle the load is in MEM, its data arrives via the WB forward a cycle later, and the MEM match is not used for a load.
  - Upstream guarantees mem_result is the ALU result. Load data arrives via wb_result.
- flush and stall asserted in the same cycle: flush wins.
- rst asserted mid-stall: the register clears on that edge.

## Configuration
- FORWARD_EN defined: MEM/WB forwarding muxes are present as above, and hazard_stall covers load-use only.
- FORWARD_EN undefined:
  - The forwarding logic is removed, and fwd_rsN equals the registered rf data.
  - hazard_stall widens to any RAW hazard: id rs (≠0) matching ex_rd_addr (ex_valid & ex_reg_write) or mem_rd_addr (mem_reg_write).
  - The register file is write-first, so WB needs no check.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all outputs 0. Then id_valid=1, card=5'b00001, rs1_data=5, rs2_data=7 -> next cycle alu_a=5, alu_b=7, alu_card=5'b00001, ex_valid=1.
- Forwarding priority: registered rs1=3; mem_rd=3 with mem_result=0xAAAA; wb_rd=3 with wb_result=0xBBBB -> alu_a=0xAAAA. Deassert mem_reg_write -> alu_a=0xBBBB. Set rs1=0 with mem_rd=0 -> alu_a=rf data.
- Load-use: EX holds a load to x5; ID uses rs2=x5 -> hazard_stall=1 for exactly 1 cycle. Next cycle EX is a bubble (alu_card=0, ex_valid=0), then the dependent instruction enters EX with alu_b=wb_result.
- Flush with stall: flush=1, stall=1, id_valid=1 -> next cycle ex_valid=0, alu_card=0. The same flush with a load-use match -> hazard_stall=0.
- Stall hold: capture an instruction with imm=0x10 and use_imm=1, then stall=1 for 3 cycles while ID changes -> alu_b stays 0x10 and ex_valid stays 1 throughout.
- FORWARD_EN off: ex_rd=4 (reg_write), ID rs1=4 -> hazard_stall=1 for 2 cycles (EX then MEM), then deasserts.
